ex_alu1_wb_arbiter: RTL and testbench



---
 rtl/ex_alu1_wb_arbiter_pkg.sv | 49 ++++
 rtl/ex_alu1_wb_fifo.sv | 58 +++++
 rtl/ex_alu1_wb_arbiter.sv | 145 ++++++++++++++
 tb/tb_ex_alu1_wb_arbiter.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_alu1_wb_arbiter_pkg.sv
// Shared definitions for the ALU1/divider writeback arbiter: payload layout
// and grant encoding.
package ex_alu1_wb_arbiter_pkg;

    localparam int TAG_W           = 6;
    localparam int REGNAME_W       = 6;
    localparam int DATA_W          = 32;
    localparam int FLAG_W          = 5;
    localparam int FLAGS_REGNAME_W = 4;

    typedef struct packed {
        logic [TAG_W-1:0]           commit_tag;
        logic                       sysreg;
        logic [REGNAME_W-1:0]       regname;
        logic                       writeback;
        logic [DATA_W-1:0]          data;
        logic [FLAG_W-1:0]          flag;
        logic                       flags_writeback;
        logic [FLAGS_REGNAME_W-1:0] flags_regname;
    } wb_payload_t;

    localparam int PAYLOAD_W = $bits(wb_payload_t);

    typedef enum logic [1:0] {
        GRANT_NONE = 2'd0,
        GRANT_ALU  = 2'd1,
        GRANT_DIV  = 2'd2
    } grant_t;

    // Divider results always write a GPR and never touch the flags.
    function automatic wb_payload_t div_to_wb(
        input logic [TAG_W-1:0]     tag,
        input logic                 sysreg,
        input logic [REGNAME_W-1:0] regname,
        input logic [DATA_W-1:0]    data
    );
        wb_payload_t p;
        p.commit_tag      = tag;
        p.sysreg          = sysreg;
        p.regname         = regname;
        p.writeback       = 1'b1;
        p.data            = data;
        p.flag            = '0;
        p.flags_writeback = 1'b0;
        p.flags_regname   = '0;
        return p;
    endfunction

endpackage

// File: rtl/ex_alu1_wb_fifo.sv
// Small synchronous FIFO holding ALU results that lost arbitration.
// Reset and clear both empty it; contents are not reset.
module ex_alu1_wb_fifo
    import ex_alu1_wb_arbiter_pkg::*;
#(
    parameter int P_WIDTH = PAYLOAD_W,
    parameter int P_DEPTH = 2
) (
    input  logic                           iCLOCK,
    input  logic                           iRESET_SYNC,
    input  logic                           clear,
    input  logic                           push,
    input  logic [P_WIDTH-1:0]             push_data,
    input  logic                           pop,
    output logic [P_WIDTH-1:0]             head_data,
    output logic [$clog2(P_DEPTH+1)-1:0]   count
);

    localparam int PW = (P_DEPTH > 1) ? $clog2(P_DEPTH) : 1;

    logic [P_WIDTH-1:0] mem [P_DEPTH];
    logic [PW-1:0]      rd_ptr;
    logic [PW-1:0]      wr_ptr;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (p == PW'(P_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge iCLOCK) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC || clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wrap_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= wrap_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head_data = mem[rd_ptr];

endmodule

// File: rtl/ex_alu1_wb_arbiter.sv
// Merges the single-cycle ALU1 result stream and the divider result stream
// onto one registered writeback port, bounding divider bursts to avoid ALU starvation.
module ex_alu1_wb_arbiter
    import ex_alu1_wb_arbiter_pkg::*;
#(
    parameter int P_ALU_DEPTH = 2,
    parameter int P_DIV_BURST = 4
) (
    input  logic        iCLOCK,
    input  logic        iRESET_SYNC,
    input  logic        iFREE_EX,
    input  logic        iALU_VALID,
    input  logic [5:0]  iALU_COMMIT_TAG,
    input  logic        iALU_SYSREG,
    input  logic [5:0]  iALU_REGNAME,
    input  logic        iALU_WRITEBACK,
    input  logic [31:0] iALU_DATA,
    input  logic [4:0]  iALU_FLAG,
    input  logic        iALU_FLAGS_WRITEBACK,
    input  logic [3:0]  iALU_FLAGS_REGNAME,
    output logic        oALU_LOCK,
    input  logic        iDIV_VALID,
    input  logic [5:0]  iDIV_COMMIT_TAG,
    input  logic        iDIV_SYSREG,
    input  logic [5:0]  iDIV_REGNAME,
    input  logic [31:0] iDIV_DATA,
    output logic        oDIV_BUSY,
    output logic        oWB_VALID,
    output logic [5:0]  oWB_COMMIT_TAG,
    output logic        oWB_SYSREG,
    output logic [5:0]  oWB_REGNAME,
    output logic        oWB_WRITEBACK,
    output logic [31:0] oWB_DATA,
    output logic [4:0]  oWB_FLAG,
    output logic        oWB_FLAGS_WRITEBACK,
    output logic [3:0]  oWB_FLAGS_REGNAME
);

    localparam int CW = $clog2(P_ALU_DEPTH + 1);
    localparam int BW = $clog2(P_DIV_BURST + 1);

    logic [CW-1:0] alu_count;
    logic [BW-1:0] burst_cnt;
    wb_payload_t   alu_live;
    wb_payload_t   alu_head;
    wb_payload_t   alu_cand_data;
    wb_payload_t   div_data;
    wb_payload_t   wb_q;
    logic          wb_valid_q;
    grant_t        grant;
    logic          active;
    logic          queue_empty;
    logic          alu_cand;
    logic          burst_limit;
    logic          alu_accept;
    logic          fifo_push;
    logic          fifo_pop;

    assign alu_live = {iALU_COMMIT_TAG, iALU_SYSREG, iALU_REGNAME, iALU_WRITEBACK,
                       iALU_DATA, iALU_FLAG, iALU_FLAGS_WRITEBACK, iALU_FLAGS_REGNAME};
    assign div_data = div_to_wb(iDIV_COMMIT_TAG, iDIV_SYSREG, iDIV_REGNAME, iDIV_DATA);

    // Reset and flush cycles neither grant nor accept anything.
    assign active        = !iRESET_SYNC && !iFREE_EX;
    assign queue_empty   = (alu_count == '0);
    assign alu_cand      = active && (!queue_empty || iALU_VALID);
    assign alu_cand_data = queue_empty ? alu_live : alu_head;
    assign burst_limit   = (burst_cnt == BW'(P_DIV_BURST));
    assign oDIV_BUSY     = alu_cand && burst_limit;

    always_comb begin
        grant = GRANT_NONE;
        if (active && iDIV_VALID && !oDIV_BUSY) begin
            grant = GRANT_DIV;
        end else if (alu_cand) begin
            grant = GRANT_ALU;
        end
    end

    // Locking one entry early keeps a same-cycle enqueue from overflowing.
    assign oALU_LOCK  = active && ((alu_count == CW'(P_ALU_DEPTH)) ||
                        ((alu_count == CW'(P_ALU_DEPTH - 1)) && (grant == GRANT_DIV)));
    assign alu_accept = active && iALU_VALID && !oALU_LOCK;
    assign fifo_push  = alu_accept && !((grant == GRANT_ALU) && queue_empty);
    assign fifo_pop   = (grant == GRANT_ALU) && !queue_empty;

    ex_alu1_wb_fifo #(
        .P_WIDTH (PAYLOAD_W),
        .P_DEPTH (P_ALU_DEPTH)
    ) u_alu_fifo (
        .iCLOCK      (iCLOCK),
        .iRESET_SYNC (iRESET_SYNC),
        .clear       (iFREE_EX),
        .push        (fifo_push),
        .push_data   (alu_live),
        .pop         (fifo_pop),
        .head_data   (alu_head),
        .count       (alu_count)
    );

    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC || iFREE_EX) begin
            burst_cnt <= '0;
        end else if ((grant == GRANT_DIV) && alu_cand) begin
            if (!burst_limit) begin
                burst_cnt <= burst_cnt + 1'b1;
            end
        end else begin
            burst_cnt <= '0;
        end
    end

    // Payload holds its last value whenever nothing is granted.
    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            wb_valid_q <= 1'b0;
            wb_q       <= '0;
        end else if (iFREE_EX) begin
            wb_valid_q <= 1'b0;
        end else begin
            case (grant)
                GRANT_DIV: begin
                    wb_valid_q <= 1'b1;
                    wb_q       <= div_data;
                end
                GRANT_ALU: begin
                    wb_valid_q <= 1'b1;
                    wb_q       <= alu_cand_data;
                end
                default: wb_valid_q <= 1'b0;
            endcase
        end
    end

    assign oWB_VALID           = wb_valid_q;
    assign oWB_COMMIT_TAG      = wb_q.commit_tag;
    assign oWB_SYSREG          = wb_q.sysreg;
    assign oWB_REGNAME         = wb_q.regname;
    assign oWB_WRITEBACK       = wb_q.writeback;
    assign oWB_DATA            = wb_q.data;
    assign oWB_FLAG            = wb_q.flag;
    assign oWB_FLAGS_WRITEBACK = wb_q.flags_writeback;
    assign oWB_FLAGS_REGNAME   = wb_q.flags_regname;

endmodule

// File: tb/tb_ex_alu1_wb_arbiter.sv
// Randomized self-checking bench for ex_alu1_wb_arbiter against a queue-based
// reference model of the arbitration rules.
module tb_ex_alu1_wb_arbiter;

    localparam int DEPTH = 2;
    localparam int BURST = 4;

    typedef struct {
        logic [1:0]  comb_o;
        logic [1:0]  comb_e;
        logic [56:0] wb_o;
        logic [56:0] wb_e;
    } cyc_t;

    logic        iCLOCK;
    logic        iRESET_SYNC;
    logic        iFREE_EX;
    logic        iALU_VALID;
    logic [5:0]  iALU_COMMIT_TAG;
    logic        iALU_SYSREG;
    logic [5:0]  iALU_REGNAME;
    logic        iALU_WRITEBACK;
    logic [31:0] iALU_DATA;
    logic [4:0]  iALU_FLAG;
    logic        iALU_FLAGS_WRITEBACK;
    logic [3:0]  iALU_FLAGS_REGNAME;
    logic        oALU_LOCK;
    logic        iDIV_VALID;
    logic [5:0]  iDIV_COMMIT_TAG;
    logic        iDIV_SYSREG;
    logic [5:0]  iDIV_REGNAME;
    logic [31:0] iDIV_DATA;
    logic        oDIV_BUSY;
    logic        oWB_VALID;
    logic [5:0]  oWB_COMMIT_TAG;
    logic        oWB_SYSREG;
    logic [5:0]  oWB_REGNAME;
    logic        oWB_WRITEBACK;
    logic [31:0] oWB_DATA;
    logic [4:0]  oWB_FLAG;
    logic        oWB_FLAGS_WRITEBACK;
    logic [3:0]  oWB_FLAGS_REGNAME;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state: producers hold beats until accepted.
    logic [55:0] alu_src[$];
    logic [44:0] div_src[$];
    logic [55:0] mq[$];
    int          streak = 0;
    logic        exp_valid = 1'b0;
    logic [55:0] exp_pl = '0;

    ex_alu1_wb_arbiter #(
        .P_ALU_DEPTH (DEPTH),
        .P_DIV_BURST (BURST)
    ) dut (
        .iCLOCK               (iCLOCK),
        .iRESET_SYNC          (iRESET_SYNC),
        .iFREE_EX             (iFREE_EX),
        .iALU_VALID           (iALU_VALID),
        .iALU_COMMIT_TAG      (iALU_COMMIT_TAG),
        .iALU_SYSREG          (iALU_SYSREG),
        .iALU_REGNAME         (iALU_REGNAME),
        .iALU_WRITEBACK       (iALU_WRITEBACK),
        .iALU_DATA            (iALU_DATA),
        .iALU_FLAG            (iALU_FLAG),
        .iALU_FLAGS_WRITEBACK (iALU_FLAGS_WRITEBACK),
        .iALU_FLAGS_REGNAME   (iALU_FLAGS_REGNAME),
        .oALU_LOCK            (oALU_LOCK),
        .iDIV_VALID           (iDIV_VALID),
        .iDIV_COMMIT_TAG      (iDIV_COMMIT_TAG),
        .iDIV_SYSREG          (iDIV_SYSREG),
        .iDIV_REGNAME         (iDIV_REGNAME),
        .iDIV_DATA            (iDIV_DATA),
        .oDIV_BUSY            (oDIV_BUSY),
        .oWB_VALID            (oWB_VALID),
        .oWB_COMMIT_TAG       (oWB_COMMIT_TAG),
        .oWB_SYSREG           (oWB_SYSREG),
        .oWB_REGNAME          (oWB_REGNAME),
        .oWB_WRITEBACK        (oWB_WRITEBACK),
        .oWB_DATA             (oWB_DATA),
        .oWB_FLAG             (oWB_FLAG),
        .oWB_FLAGS_WRITEBACK  (oWB_FLAGS_WRITEBACK),
        .oWB_FLAGS_REGNAME    (oWB_FLAGS_REGNAME)
    );

    initial iCLOCK = 1'b0;
    always #5 iCLOCK = ~iCLOCK;

    function automatic logic [55:0] mk_alu(input logic [5:0] tag, input logic [31:0] data);
        return {tag, 1'($urandom), 6'($urandom), 1'($urandom), data,
                5'($urandom), 1'($urandom), 4'($urandom)};
    endfunction

    function automatic logic [44:0] mk_div(input logic [5:0] tag, input logic [31:0] data);
        return {tag, 1'($urandom), 6'($urandom), data};
    endfunction

    // Drives one cycle from the producer queues, advances the model and
    // returns observed/expected values: lock+busy before the edge, writeback after it.
    task automatic applyStimulus(input logic flush, input logic rst, output cyc_t r);
        logic [55:0] live;
        logic [55:0] head;
        logic [55:0] divp;
        logic [44:0] dsrc;
        logic        cand;
        logic        busy_e;
        logic        lock_e;
        logic        div_win;
        logic        acc;
        logic        bypass;
        live = 56'({$urandom(), $urandom()});
        if (alu_src.size() > 0) live = alu_src[0];
        dsrc = 45'({$urandom(), $urandom()});
        if (div_src.size() > 0) dsrc = div_src[0];
        iRESET_SYNC = rst;
        iFREE_EX    = flush;
        iALU_VALID  = (alu_src.size() > 0);
        {iALU_COMMIT_TAG, iALU_SYSREG, iALU_REGNAME, iALU_WRITEBACK, iALU_DATA,
         iALU_FLAG, iALU_FLAGS_WRITEBACK, iALU_FLAGS_REGNAME} = live;
        iDIV_VALID  = (div_src.size() > 0);
        {iDIV_COMMIT_TAG, iDIV_SYSREG, iDIV_REGNAME, iDIV_DATA} = dsrc;
        divp = {dsrc[44:32], 1'b1, dsrc[31:0], 10'd0};

        @(negedge iCLOCK);
        if (rst || flush) begin
            busy_e = 1'b0;
            lock_e = 1'b0;
            mq.delete();
            alu_src.delete();
            div_src.delete();
            streak    = 0;
            exp_valid = 1'b0;
            if (rst) exp_pl = '0;
        end else begin
            cand    = (mq.size() > 0) || (alu_src.size() > 0);
            head    = (mq.size() > 0) ? mq[0] : live;
            busy_e  = cand && (streak == BURST);
            div_win = (div_src.size() > 0) && !busy_e;
            lock_e  = (mq.size() == DEPTH) || ((mq.size() == DEPTH - 1) && div_win);
            acc     = (alu_src.size() > 0) && !lock_e;
            bypass  = !div_win && cand && (mq.size() == 0);
            if (div_win) begin
                exp_valid = 1'b1;
                exp_pl    = divp;
                void'(div_src.pop_front());
                streak = cand ? ((streak < BURST) ? streak + 1 : BURST) : 0;
            end else if (cand) begin
                exp_valid = 1'b1;
                exp_pl    = head;
                streak    = 0;
                if (mq.size() > 0) void'(mq.pop_front());
            end else begin
                exp_valid = 1'b0;
                streak    = 0;
            end
            if (acc) begin
                if (!bypass) mq.push_back(live);
                void'(alu_src.pop_front());
            end
        end
        r.comb_o = {oALU_LOCK, oDIV_BUSY};
        r.comb_e = {lock_e, busy_e};

        @(posedge iCLOCK);
        #1;
        r.wb_o = {oWB_VALID, oWB_COMMIT_TAG, oWB_SYSREG, oWB_REGNAME, oWB_WRITEBACK,
                  oWB_DATA, oWB_FLAG, oWB_FLAGS_WRITEBACK, oWB_FLAGS_REGNAME};
        r.wb_e = {exp_valid, exp_pl};
    endtask

    task automatic test_reset();
        cyc_t r;
        for (int i = 0; i < 3; i++) begin
            alu_src.push_back(mk_alu(6'($urandom), $urandom));
            div_src.push_back(mk_div(6'($urandom), $urandom));
            applyStimulus(1'b0, 1'b1, r);
            vectors++;
            if (r.comb_o !== 2'b00) begin
                miscompares++;
                $display("[TB] FAIL reset_lock_busy cyc %0d: got %b want 00", i, r.comb_o);
            end
            vectors++;
            if (r.wb_o !== 57'd0) begin
                miscompares++;
                $display("[TB] FAIL reset_wb cyc %0d: got %h want 0", i, r.wb_o);
            end
        end
    endtask

    task automatic test_alu_only();
        cyc_t r;
        alu_src.push_back(mk_alu(6'h05, 32'h1234));
        applyStimulus(1'b0, 1'b0, r);
        vectors++;
        if (oWB_VALID !== 1'b1 || oWB_COMMIT_TAG !== 6'h05 || oWB_DATA !== 32'h1234) begin
            miscompares++;
            $display("[TB] FAIL alu_only_beat: got v=%b tag=%h data=%h want v=1 tag=05 data=1234",
                     oWB_VALID, oWB_COMMIT_TAG, oWB_DATA);
        end
        for (int i = 0; i < 6; i++) begin
            if (i < 4) alu_src.push_back(mk_alu(6'($urandom), $urandom));
            applyStimulus(1'b0, 1'b0, r);
            vectors++;
            if (r.comb_o !== r.comb_e) begin
                miscompares++;
                $display("[TB] FAIL alu_only_lock_busy cyc %0d: got %b want %b", i, r.comb_o, r.comb_e);
            end
            vectors++;
            if (r.wb_o !== r.wb_e) begin
                miscompares++;
                $display("[TB] FAIL alu_only_wb cyc %0d: got %h want %h", i, r.wb_o, r.wb_e);
            end
        end
    endtask

    task automatic test_collision();
        cyc_t r;
        alu_src.push_back(mk_alu(6'h01, $urandom));
        div_src.push_back(mk_div(6'h02, $urandom));
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, r);
            vectors++;
            if (r.wb_o !== r.wb_e || r.comb_o[1] !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL collision cyc %0d: got wb=%h lock=%b want wb=%h lock=0",
                         i, r.wb_o, r.comb_o[1], r.wb_e);
            end
            if (i == 0) begin
                vectors++;
                if (r.wb_o[55:50] !== 6'h02 || r.wb_o[42] !== 1'b1 || r.wb_o[9:5] !== 5'd0) begin
                    miscompares++;
                    $display("[TB] FAIL collision_div_first: got tag=%h wb=%b flag=%h want tag=02 wb=1 flag=00",
                             r.wb_o[55:50], r.wb_o[42], r.wb_o[9:5]);
                end
            end else if (i == 1) begin
                vectors++;
                if (r.wb_o[56] !== 1'b1 || r.wb_o[55:50] !== 6'h01) begin
                    miscompares++;
                    $display("[TB] FAIL collision_alu_second: got v=%b tag=%h want v=1 tag=01",
                             r.wb_o[56], r.wb_o[55:50]);
                end
            end
        end
    endtask

    task automatic test_starvation();
        cyc_t r;
        int   alu_idx = -1;
        logic busy_at_alu = 1'b0;
        for (int k = 0; k < 8; k++) div_src.push_back(mk_div(6'(6'h20 + k), $urandom));
        alu_src.push_back(mk_alu(6'h10, $urandom));
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 1'b0, r);
            vectors++;
            if (r.comb_o !== r.comb_e) begin
                miscompares++;
                $display("[TB] FAIL starve_lock_busy cyc %0d: got %b want %b", i, r.comb_o, r.comb_e);
            end
            vectors++;
            if (r.wb_o !== r.wb_e) begin
                miscompares++;
                $display("[TB] FAIL starve_wb cyc %0d: got %h want %h", i, r.wb_o, r.wb_e);
            end
            if (r.wb_o[56] === 1'b1 && r.wb_o[55:50] === 6'h10) begin
                alu_idx     = i;
                busy_at_alu = r.comb_o[0];
            end
        end
        vectors++;
        if (alu_idx != 4 || busy_at_alu !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL starve_alu_slot: got cycle %0d busy %b want cycle 4 busy 1", alu_idx, busy_at_alu);
        end
    endtask

    task automatic test_full();
        cyc_t r;
        logic lock_seen = 1'b0;
        for (int k = 0; k < 12; k++) div_src.push_back(mk_div(6'($urandom), $urandom));
        for (int k = 0; k < 10; k++) alu_src.push_back(mk_alu(6'(k), $urandom));
        for (int i = 0; i < 40; i++) begin
            applyStimulus(1'b0, 1'b0, r);
            vectors++;
            if (r.comb_o !== r.comb_e) begin
                miscompares++;
                $display("[TB] FAIL full_lock_busy cyc %0d: got %b want %b", i, r.comb_o, r.comb_e);
            end
            vectors++;
            if (r.wb_o !== r.wb_e) begin
                miscompares++;
                $display("[TB] FAIL full_wb cyc %0d: got %h want %h", i, r.wb_o, r.wb_e);
            end
            if (r.comb_o[1] === 1'b1) lock_seen = 1'b1;
            if (alu_src.size() == 0 && div_src.size() == 0 && mq.size() == 0) break;
        end
        vectors++;
        if (lock_seen !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL full_lock_seen: got %b want 1", lock_seen);
        end
    endtask

    task automatic test_flush();
        cyc_t r;
        for (int k = 0; k < 4; k++) div_src.push_back(mk_div(6'($urandom), $urandom));
        for (int k = 0; k < 3; k++) alu_src.push_back(mk_alu(6'(6'h30 + k), $urandom));
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, 1'b0, r);
            vectors++;
            if (r.comb_o !== r.comb_e || r.wb_o !== r.wb_e) begin
                miscompares++;
                $display("[TB] FAIL flush_fill cyc %0d: got %b/%h want %b/%h",
                         i, r.comb_o, r.wb_o, r.comb_e, r.wb_e);
            end
        end
        applyStimulus(1'b1, 1'b0, r);
        vectors++;
        if (r.wb_o[56] !== 1'b0 || r.comb_o !== 2'b00 || r.wb_o !== r.wb_e) begin
            miscompares++;
            $display("[TB] FAIL flush_cycle: got lock_busy=%b wb=%h want 00 wb=%h", r.comb_o, r.wb_o, r.wb_e);
        end
        alu_src.push_back(mk_alu(6'h2A, $urandom));
        applyStimulus(1'b0, 1'b0, r);
        vectors++;
        if (r.wb_o !== r.wb_e || r.comb_o !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL flush_after: got %b/%h want 00/%h", r.comb_o, r.wb_o, r.wb_e);
        end
    endtask

    task automatic test_reset_mid();
        cyc_t r;
        for (int k = 0; k < 8; k++) div_src.push_back(mk_div(6'($urandom), $urandom));
        alu_src.push_back(mk_alu(6'h11, $urandom));
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, r);
            vectors++;
            if (r.comb_o !== r.comb_e || r.wb_o !== r.wb_e) begin
                miscompares++;
                $display("[TB] FAIL rst_mid_burst cyc %0d: got %b/%h want %b/%h",
                         i, r.comb_o, r.wb_o, r.comb_e, r.wb_e);
            end
        end
        applyStimulus(1'b0, 1'b1, r);
        vectors++;
        if (r.wb_o !== 57'd0 || r.comb_o !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL rst_mid_outputs: got %b/%h want 00/0", r.comb_o, r.wb_o);
        end
        alu_src.push_back(mk_alu(6'h33, 32'hCAFE_0001));
        applyStimulus(1'b0, 1'b0, r);
        vectors++;
        if (oWB_VALID !== 1'b1 || oWB_COMMIT_TAG !== 6'h33 || oWB_DATA !== 32'hCAFE_0001) begin
            miscompares++;
            $display("[TB] FAIL rst_mid_first_alu: got v=%b tag=%h data=%h want v=1 tag=33 data=cafe0001",
                     oWB_VALID, oWB_COMMIT_TAG, oWB_DATA);
        end
    endtask

    task automatic test_random();
        cyc_t r;
        logic flush;
        logic rst;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 2) != 0 && alu_src.size() < 4)
                alu_src.push_back(mk_alu(6'($urandom), $urandom));
            if ($urandom_range(0, 1) != 0 && div_src.size() < 4)
                div_src.push_back(mk_div(6'($urandom), $urandom));
            flush = ($urandom_range(0, 39) == 0);
            rst   = ($urandom_range(0, 99) == 0);
            applyStimulus(flush, rst, r);
            vectors++;
            if (r.comb_o !== r.comb_e) begin
                miscompares++;
                $display("[TB] FAIL random_lock_busy cyc %0d: got %b want %b", i, r.comb_o, r.comb_e);
            end
            vectors++;
            if (r.wb_o !== r.wb_e) begin
                miscompares++;
                $display("[TB] FAIL random_wb cyc %0d: got %h want %h", i, r.wb_o, r.wb_e);
            end
        end
    endtask

    initial begin
        iRESET_SYNC = 1'b1;
        iFREE_EX    = 1'b0;
        iALU_VALID  = 1'b0;
        iDIV_VALID  = 1'b0;
        {iALU_COMMIT_TAG, iALU_SYSREG, iALU_REGNAME, iALU_WRITEBACK, iALU_DATA,
         iALU_FLAG, iALU_FLAGS_WRITEBACK, iALU_FLAGS_REGNAME} = '0;
        {iDIV_COMMIT_TAG, iDIV_SYSREG, iDIV_REGNAME, iDIV_DATA} = '0;
        @(posedge iCLOCK);
        #1;
        test_reset();
        test_alu_only();
        test_collision();
        test_starvation();
        test_full();
        test_flush();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
